// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory port between four ring-buffer clients
module mem_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [3:0]            we,
    input  logic [4*ADDR_W-1:0]   addr,
    input  logic [4*DATA_W-1:0]   wdata,
    output logic [3:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t              state_q, state_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          idx_q, idx_d;
    logic                we_lat_q, we_lat_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;

    logic                found;
    logic [1:0]          sel;
    logic [1:0]          cand;
    int                  sel_i;

    // Round-robin search starting just after the last granted client, wrapping
    always_comb begin
        found = 1'b0;
        sel   = 2'd0;
        cand  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        sel_i = int'(sel);
    end

    // Next-state and registered-output computation; outputs track the state being entered
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        idx_d       = idx_q;
        we_lat_d    = we_lat_q;
        cnt_d       = cnt_q;
        ack_d       = 4'b0000;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d       = sel;
                    we_lat_d    = we[sel];
                    mem_addr_d  = addr[sel_i*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata[sel_i*DATA_W +: DATA_W];
                    mem_we_d    = we[sel];
                    mem_re_d    = !we[sel];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (we_lat_q) begin
                    ack_d   = 4'b0001 << idx_q;
                    state_d = ACK;
                end else begin
                    cnt_d   = 4'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = mem_rdata;
                    ack_d   = 4'b0001 << idx_q;
                    state_d = ACK;
                end
            end
            ACK: begin
                last_d  = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 2'd3;
            idx_q       <= 2'd0;
            we_lat_q    <= 1'b0;
            cnt_q       <= 4'd0;
            ack_q       <= 4'b0000;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            we_lat_q    <= we_lat_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

endmodule
